// File: rtl/instr_encoder_if.sv
// Instruction request bundle for the RV32 encoder.
// Master drives the request fields, slave answers with in_ready.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7,
    output in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7,
    input  in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32 instruction encoder writing words into an instruction memory image.
// Build option ENC_NOP_PAD_EN: on flush, fill the image tail with NOPs.
module instr_encoder #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_encoder_if.slave    req,
  input  logic              flush,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]     NOP = 32'h0000_0013;

`ifdef ENC_NOP_PAD_EN
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PAD  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_cnt;
  logic              r_err;

  logic        w_full;
  logic        w_ready;
  logic        w_hs;
  logic        w_legal;
  logic        w_wr;
  logic        w_pad;
  logic [31:0] w_enc;
  logic [12:0] w_imm;
  logic        w_k_r;
  logic        w_k_i;
  logic        w_k_lw;
  logic        w_k_sw;
  logic        w_k_beq;
  logic        w_unused_imm0;

  assign w_imm         = req.in_imm;
  assign w_unused_imm0 = w_imm[0];

  assign w_full  = (r_cnt == CAP);
  assign w_ready = rst_n && !restart && !flush
                && (r_state == S_RUN) && !w_full;
  assign w_hs    = req.in_valid && w_ready;
  assign w_legal = (req.in_kind < 3'd5);
  assign w_wr    = w_hs && w_legal;

`ifdef ENC_NOP_PAD_EN
  assign w_pad = (r_state == S_PAD) && !w_full && !restart;
`else
  assign w_pad = 1'b0;
`endif

  assign w_k_r   = (req.in_kind == 3'd0);
  assign w_k_i   = (req.in_kind == 3'd1);
  assign w_k_lw  = (req.in_kind == 3'd2);
  assign w_k_sw  = (req.in_kind == 3'd3);
  assign w_k_beq = (req.in_kind == 3'd4);

  assign req.in_ready  = w_ready;
  assign imem_we       = r_we;
  assign imem_addr     = r_addr;
  assign imem_wdata    = r_wdata;
  assign done          = (r_state == S_DONE);
  assign err           = r_err;
  assign words_written = r_cnt;

  // Pack the request fields into the RV32 word for its kind.
  always_comb begin
    w_enc = '0;
    unique case (1'b1)
      w_k_r:   w_enc = {req.in_funct7, req.in_rs2, req.in_rs1,
                        req.in_funct3, req.in_rd, 7'b0110011};
      w_k_i:   w_enc = {w_imm[11:0], req.in_rs1, req.in_funct3,
                        req.in_rd, 7'b0010011};
      w_k_lw:  w_enc = {w_imm[11:0], req.in_rs1, 3'b010,
                        req.in_rd, 7'b0000011};
      w_k_sw:  w_enc = {w_imm[11:5], req.in_rs2, req.in_rs1,
                        3'b010, w_imm[4:0], 7'b0100011};
      w_k_beq: w_enc = {w_imm[12], w_imm[10:5], req.in_rs2,
                        req.in_rs1, 3'b000, w_imm[4:1],
                        w_imm[11], 7'b1100011};
      default: w_enc = '0;
    endcase
  end

  // Next state: flush or a full image closes it, restart reopens.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (flush) begin
`ifdef ENC_NOP_PAD_EN
          w_next = S_PAD;
`else
          w_next = S_DONE;
`endif
        end else if (w_full) begin
          w_next = S_DONE;
        end
      end
`ifdef ENC_NOP_PAD_EN
      S_PAD:   if (w_full) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_DONE;
      default: w_next = S_RUN;
    endcase
    if (restart) w_next = S_RUN;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_next;
  end

  // Write port, word counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (restart) begin
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_wr || w_pad;
      if (w_wr || w_pad) begin
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_wdata <= w_pad ? NOP : w_enc;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_hs && !w_legal) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder with a 4-word image.
// Vector table plus write scoreboard and hand-written corner sequences.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          restart = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic          err;
  logic [AW:0]   words_written;

  instr_encoder_if req_if ();

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req_if),
    .flush         (flush),
    .restart       (restart),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  vec_t vt[8];
  vec_t bad;
  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   m_addr = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected write: addr %0d data %h",
                 imem_addr, imem_wdata);
      end else begin
        e = q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %0d data %h want addr %0d data %h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    req_if.in_kind   = v.kind;
    req_if.in_funct3 = v.f3;
    req_if.in_funct7 = v.f7;
    req_if.in_rd     = v.rd;
    req_if.in_rs1    = v.rs1;
    req_if.in_rs2    = v.rs2;
    req_if.in_imm    = v.imm;
  endtask

  task automatic send(input vec_t v, input bit push);
    int n;
    @(negedge clk);
    drive(v);
    req_if.in_valid = 1'b1;
    #1;
    n = 0;
    while (!req_if.in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_if.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send timeout: kind %0d", v.kind);
      req_if.in_valid = 1'b0;
      return;
    end
    if (push && v.kind < 3'd5) begin
      q.push_back('{addr: AW'(m_addr), data: v.exp});
      m_addr++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_if.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk);
    req_if.in_valid = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    m_addr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    //          kind  f3    f7     rd    rs1   rs2   imm          exp
    vt[0] = '{3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 13'd5,      32'h0050_0093};
    vt[1] = '{3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 13'd0,      32'h0020_81B3};
    vt[2] = '{3'd2, 3'd0, 7'h00, 5'd5, 5'd1, 5'd0, 13'd4,      32'h0040_A283};
    vt[3] = '{3'd3, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 13'd8,      32'h0020_A423};
    vt[4] = '{3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 13'h1FF8,   32'hFE20_8CE3};
    vt[5] = '{3'd4, 3'd7, 7'h7F, 5'd7, 5'd1, 5'd2, 13'h1FF9,   32'hFE20_8CE3};
    vt[6] = '{3'd1, 3'd0, 7'h55, 5'd2, 5'd2, 5'd31, 13'h1FFF,  32'hFFF1_0113};
    vt[7] = '{3'd0, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 13'd0,      32'h4062_8233};
    bad   = '{3'd6, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 13'd0,      32'h0};

    req_if.in_valid = 1'b0;
    drive(vt[0]);

    repeat (2) @(negedge clk);
    chk("rst in_ready", req_if.in_ready, 0);
    chk("rst imem_we", imem_we, 0);
    chk("rst imem_addr", imem_addr, 0);
    chk("rst imem_wdata", imem_wdata, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst words", words_written, 0);
    rst_n = 1'b1;

    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 4; j++) send(vt[g*4+j], 1'b1);
      @(negedge clk);
      drive(vt[0]);
      req_if.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #1;
        chk("full in_ready", req_if.in_ready, 0);
        @(negedge clk);
      end
      req_if.in_valid = 1'b0;
      chk("full done", done, 1);
      chk("full words", words_written, 4);
      do_restart();
      chk("restart words", words_written, 0);
      chk("restart done", done, 0);
    end

    send(bad, 1'b1);
    idle(3);
    chk("illegal err", err, 1);
    chk("illegal words", words_written, 0);
    do_restart();
    chk("restart err", err, 0);
    chk("restart words2", words_written, 0);

    send(vt[0], 1'b1);
    @(negedge clk);
    drive(vt[1]);
    req_if.in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush in_ready", req_if.in_ready, 0);
`ifdef ENC_NOP_PAD_EN
    for (int a = 1; a < 4; a++) begin
      q.push_back('{addr: AW'(a), data: 32'h0000_0013});
    end
`endif
    @(negedge clk);
    flush = 1'b0;
    req_if.in_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("flush done", done, 1);
`ifdef ENC_NOP_PAD_EN
    chk("flush words", words_written, 4);
`else
    chk("flush words", words_written, 1);
`endif
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("done hold", done, 1);
    chk("done in_ready", req_if.in_ready, 0);

    do_restart();
    send(vt[2], 1'b0);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    req_if.in_valid = 1'b0;
    chk("midrst we", imem_we, 0);
    chk("midrst words", words_written, 0);
    rst_n = 1'b1;
    m_addr = 0;
    send(vt[3], 1'b1);
    idle(3);
    chk("post rst words", words_written, 1);
    chk("queue drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 9, instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  instruction request valid.
REQ-005 in_ready  output  1  encoder accepts request this cycle.
REQ-006 in_kind  input  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BEQ, 5..7 illegal.
REQ-007 in_funct3 / in_funct7  input  3 / 7  ALU function fields (R, I-ALU only).
REQ-008 in_rd / in_rs1 / in_rs2  input  5 each  register indices.
REQ-009 in_imm  input  13  signed immediate; bits [11:0] for I-ALU/LW/SW, bits [12:0] byte offset for BEQ.
REQ-010 flush  input  1  end of program; close the image.
REQ-011 restart  input  1  single-cycle pulse; start new image at address 0.
REQ-012 imem_we / imem_addr / imem_wdata  output  1 / ADDR_W / 32  instruction-memory write port.
REQ-013 done  output  1  image closed, no further writes.
REQ-014 err  output  1  sticky; an illegal in_kind was presented.
REQ-015 words_written  output  ADDR_W+1  count of words written since reset/restart.

Function
REQ-016 Encoding, opcode in [6:0]: R {funct7,rs2,rs1,funct3,rd,0110011}; I-ALU {imm[11:0],rs1,funct3,rd,0010011}; LW {imm[11:0],rs1,010,rd,0000011}; SW {imm[11:5],rs2,rs1,010,imm[4:0],0100011}; BEQ {imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011}.
REQ-017 Unused fields per kind are ignored; BEQ imm[0] ignored.
REQ-018 States: RUN, PAD, DONE; reset and restart enter RUN.
REQ-019 in_ready = 1 only in RUN with flush=0 and words_written < 2^ADDR_W.
REQ-020 Handshake = in_valid & in_ready; encoded word registered, imem_we=1 exactly on the following cycle; imem_addr = words_written at handshake; 1 word/cycle sustained.
REQ-021 words_written increments by 1 on every imem_we cycle.
REQ-022 Illegal in_kind on handshake: no write, counter unchanged, err set until reset/restart.
REQ-023 Capacity: once words_written reaches 2^ADDR_W, go to DONE; address never wraps.
REQ-024 flush in RUN: a same-cycle in_valid is not accepted (flush wins); a pending registered write still completes next cycle; then PAD (if enabled, REQ-030) or DONE.
REQ-025 DONE: in_ready=0, imem_we=0, done=1; flush ignored; exit only via restart or reset.
REQ-026 restart in any state: cancels pending write and padding; next cycle state=RUN, words_written=0, err=0, done=0.
REQ-027 imem_we=0 whenever no write is due; imem_wdata/imem_addr hold last value.

Reset
REQ-028 rst_n low asynchronously forces: state RUN, in_ready 0 while rst_n low, imem_we 0, imem_addr 0, imem_wdata 0, done 0, err 0, words_written 0; pending write discarded.
REQ-029 Reset mid-image abandons that image; first write after release goes to address 0.

Configuration
REQ-030 Macro ENC_NOP_PAD_EN defined: PAD writes NOP 0x00000013 once per cycle at successive addresses until words_written = 2^ADDR_W, then DONE. Undefined: PAD state absent; flush goes straight to DONE after any pending write; unwritten words untouched.

Verification
REQ-031 I-ALU rd=1 rs1=0 f3=0 imm=5 -> one cycle later imem_we=1, addr 0, wdata 0x00500093; R rd=3 rs1=1 rs2=2 f3=0 f7=0 back-to-back -> addr 1, 0x002081B3.
REQ-032 LW rd=5 rs1=1 imm=4 -> 0x0040A283; SW rs1=1 rs2=2 imm=8 -> 0x0020A423; BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3.
REQ-033 ADDR_W=2, 4 valid requests every cycle -> addrs 0..3, words_written=4, done=1, in_ready=0; 5th request never accepted.
REQ-034 ADDR_W=2, 1 instruction then flush: with ENC_NOP_PAD_EN -> addrs 1..3 get 0x00000013, done=1, words_written=4; without -> done=1, words_written=1.
REQ-035 in_kind=6 with in_valid -> no imem_we, err=1; restart pulse -> err=0, words_written=0, next write at addr 0.
REQ-036 rst_n low in the cycle after a handshake -> no imem_we; after release, first accepted instruction written at addr 0.
